karatsuba_mul_seq: RTL and testbench
====================================

KARATSUBA_MUL_SEQ -- requirements
Module: karatsuba_mul_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 256, giving the operand width in bits; WIDTH SHALL be even and >= 8, else elaboration SHALL fail.
REQ-002 The block SHALL derive the constant H = WIDTH/2 (half width) and LAT = 3*(H+1)+2 (acceptance-to-result latency in cycles).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand pair a/b valid.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 a  input  WIDTH  unsigned multiplicand.
REQ-008 b  input  WIDTH  unsigned multiplier.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 result  output  2*WIDTH  unsigned product a*b.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 An operand pair SHALL be accepted on an edge where in_valid and in_ready are both high; a and b SHALL be registered on that edge and SHALL not be sampled again.
REQ-014 in_ready SHALL be high only in IDLE; the block SHALL process one operation at a time (no pipelining).
REQ-015 The split SHALL be binary at bit H: a1=a[WIDTH-1:H], a0=a[H-1:0]; b1 and b0 SHALL follow the same rule.
REQ-016 The FSM SHALL have the states IDLE, MUL0, MUL1, MUL2, COMB and DONE.
REQ-017 On acceptance the FSM SHALL go IDLE->MUL0.
REQ-018 MUL0 SHALL compute t0=a0*b0, MUL1 SHALL compute t1=a1*b1, and MUL2 SHALL compute s=(a1+a0)*(b1+b0).
REQ-019 Each of MUL0, MUL1 and MUL2 SHALL last exactly H+1 cycles, using one shared sub-multiplier with (H+1)-bit operands.
REQ-020 COMB SHALL last one cycle and SHALL compute result = (t1<<2H) + ((s-t0-t1)<<H) + t0.
REQ-021 Internal widths in COMB: s SHALL be 2H+2 bits; the middle term SHALL be 2H+2 bits; the final sum SHALL be truncated to 2*WIDTH bits, which is lossless.
REQ-022 out_valid SHALL rise exactly LAT edges after the acceptance edge and SHALL hold, with result stable, until an edge where out_ready is high; on that edge the FSM SHALL go DONE->IDLE.
REQ-023 out_valid and in_ready SHALL never be high in the same cycle; the next acceptance is therefore possible at the earliest one cycle after the result handshake.
REQ-024 result SHALL keep its last value after the handshake until the next COMB (or zero-skip) update.
REQ-025 If out_ready is already high when out_valid rises, the result SHALL be consumed on the first edge that out_valid is high.

Reset
REQ-026 While rst is high at an edge, the block SHALL force: state IDLE, in_ready=1 (effective from the following cycle), out_valid=0, busy=0, result=0, all partial products cleared, sub-multiplier idle.
REQ-027 rst SHALL take priority over every handshake; a reset mid-operation SHALL discard the operation, and no out_valid SHALL follow from it.

Configuration
REQ-028 The feature SHALL be controlled by the macro KARATSUBA_ZERO_SKIP_EN.
REQ-029 With KARATSUBA_ZERO_SKIP_EN defined: an accepted pair with a==0 or b==0 SHALL go IDLE->DONE, result=0 and out_valid high 1 edge after acceptance; all other pairs SHALL behave per REQ-022.
REQ-030 Without KARATSUBA_ZERO_SKIP_EN: every pair, including zero operands, SHALL take LAT cycles.

Structure
REQ-031 The package kmul_pkg SHALL hold the FSM state enum type and a function computing LAT from WIDTH.
REQ-032 The sub-module shift_add_mul SHALL be a parametrised iterative unsigned multiplier: start pulse, (H+1)-bit operands, one bit per cycle, done after exactly H+1 cycles, 2H+2-bit product.

Verification
REQ-033 WIDTH=16 (LAT=29), a=0x1234, b=0x5678, out_ready=1 -> out_valid rises 29 edges after acceptance with result=0x06260060; in_ready low throughout.
REQ-034 WIDTH=16, a=0xFFFF, b=0xFFFF (carry into the middle term) -> result=0xFFFE0001.
REQ-035 WIDTH=16, a=0x0000, b=0xABCD -> result=0; latency 1 with KARATSUBA_ZERO_SKIP_EN, 29 without.
REQ-036 out_ready held low for 10 cycles after out_valid rises -> result stable and in_ready=0 for those 10 cycles; after out_ready goes high, in_ready=1 on the next cycle.
REQ-037 rst pulsed at edge 12 of an operation -> out_valid stays 0, in_ready=1 next cycle; a new pair 0x0003*0x0005 -> result=0x0000000F.
REQ-038 WIDTH=256, 1000 random pairs plus all-ones and single-bit patterns, random out_ready stalls -> every result equals the reference product, in order.

Source files
------------

// File: rtl/kmul_pkg.sv
// ----------------------------------------------------------------------------
// kmul_pkg: shared FSM state type and latency helper for karatsuba_mul_seq.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package kmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL0 = 3'd1,
    ST_MUL1 = 3'd2,
    ST_MUL2 = 3'd3,
    ST_COMB = 3'd4,
    ST_DONE = 3'd5
  } kmul_state_e;

  // Three half-width products of H+1 cycles each, one combine cycle, one settle cycle.
  function automatic int kmul_lat(input int width);
    return 3 * (width / 2 + 1) + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_add_mul.sv
// ----------------------------------------------------------------------------
// shift_add_mul: iterative unsigned N x N multiplier, one multiplier bit per cycle.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module shift_add_mul #(
  parameter int N = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     op_a,
  input  logic [N-1:0]     op_b,
  output logic             done,
  output logic [2*N-1:0]   product
);

  localparam int CW = $clog2(N + 1);

  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           active_q, active_d;

  // Bit 0 is folded into the start cycle so N edges cover all N bits.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      acc_d    = op_b[0] ? {{N{1'b0}}, op_a} : '0;
      mcand_d  = {{(N-1){1'b0}}, op_a, 1'b0};
      mplier_d = op_b >> 1;
      cnt_d    = CW'(N - 1);
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q != '0) begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
      end else begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done    = active_q && (cnt_q == '0);
  assign product = acc_q;

endmodule

`default_nettype wire

// File: rtl/karatsuba_mul_seq.sv
// ----------------------------------------------------------------------------
// karatsuba_mul_seq: sequential one-level Karatsuba multiplier over a shared
// shift-add core. Option macro KARATSUBA_ZERO_SKIP_EN short-cuts zero operands.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module karatsuba_mul_seq
  import kmul_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  localparam int H   = WIDTH / 2;
  localparam int M   = H + 1;
  localparam int LAT = kmul_lat(WIDTH);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 8 || LAT < 17) begin : g_width_check
      $error("karatsuba_mul_seq: WIDTH must be even and >= 8");
    end
  endgenerate

  kmul_state_e          state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*H-1:0]       t0_q, t0_d, t1_q, t1_d;
  logic [2*H+1:0]       s_q, s_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 out_valid_q, out_valid_d;

  logic                 accept, handshake, zero_op;
  logic                 mul_start, mul_done;
  logic [M-1:0]         mul_a, mul_b;
  logic [2*M-1:0]       mul_prod;
  logic [2*H+1:0]       mid;

  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_q && out_ready;

`ifdef KARATSUBA_ZERO_SKIP_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Each product's start coincides with the edge that ends the previous phase.
  assign mul_start = (accept && !zero_op) ||
                     (mul_done && (state_q == ST_MUL0 || state_q == ST_MUL1));

  always_comb begin
    mul_a = {1'b0, a[H-1:0]};
    mul_b = {1'b0, b[H-1:0]};
    if (state_q == ST_MUL0) begin
      mul_a = {1'b0, a_q[WIDTH-1:H]};
      mul_b = {1'b0, b_q[WIDTH-1:H]};
    end else if (state_q == ST_MUL1) begin
      mul_a = {1'b0, a_q[WIDTH-1:H]} + {1'b0, a_q[H-1:0]};
      mul_b = {1'b0, b_q[WIDTH-1:H]} + {1'b0, b_q[H-1:0]};
    end
  end

  shift_add_mul #(
    .N (M)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .op_a    (mul_a),
    .op_b    (mul_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign mid = s_q - {2'b00, t0_q} - {2'b00, t1_q};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    t0_d     = t0_q;
    t1_d     = t1_q;
    s_d      = s_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d = a;
          b_d = b;
          if (zero_op) begin
            result_d = '0;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_MUL0;
          end
        end
      end
      ST_MUL0: begin
        if (mul_done) begin
          t0_d    = mul_prod[2*H-1:0];
          state_d = ST_MUL1;
        end
      end
      ST_MUL1: begin
        if (mul_done) begin
          t1_d    = mul_prod[2*H-1:0];
          state_d = ST_MUL2;
        end
      end
      ST_MUL2: begin
        if (mul_done) begin
          s_d     = mul_prod;
          state_d = ST_COMB;
        end
      end
      ST_COMB: begin
        result_d = {t1_q, {(2*H){1'b0}}}
                 + ({{(2*H-2){1'b0}}, mid} << H)
                 + {{(2*H){1'b0}}, t0_q};
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (handshake) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // out_valid trails DONE entry by one edge and drops on the handshake edge.
  assign out_valid_d = (state_q == ST_DONE) && !handshake;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      t0_q        <= '0;
      t1_q        <= '0;
      s_q         <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      t0_q        <= t0_d;
      t1_q        <= t1_d;
      s_q         <= s_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

`default_nettype wire

// File: tb/tb_karatsuba_mul_seq.sv
// ----------------------------------------------------------------------------
// tb_karatsuba_mul_seq: directed and randomized checks of karatsuba_mul_seq
// (WIDTH=16) against plain integer multiplication. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_karatsuba_mul_seq;

  localparam int WIDTH = 16;
  localparam int H     = WIDTH / 2;
  localparam int LAT   = 3 * (H + 1) + 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a, b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  karatsuba_mul_seq #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef KARATSUBA_ZERO_SKIP_EN
    if (x == '0 || y == '0) return 1;
`endif
    return LAT;
  endfunction

  // One full transaction: accept, wait for the result, optional stall, handshake.
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int stall);
    logic [2*WIDTH-1:0] want;
    int lat, wait_n;
    bit bad_ready, bad_busy, bad_hold;
    want   = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
    wait_n = 0;
    while (!in_ready && wait_n < 100) begin
      step();
      wait_n++;
    end
    chk_eq("in_ready_before", 64'(in_ready), 64'd1);
    out_ready = (stall == 0);
    a         = x;
    b         = y;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    a         = WIDTH'($urandom);
    b         = WIDTH'($urandom);
    lat       = 0;
    bad_ready = 0;
    bad_busy  = 0;
    while (!out_valid && lat < LAT + 20) begin
      if (in_ready) bad_ready = 1;
      if (!busy)    bad_busy  = 1;
      step();
      lat++;
    end
    chk_eq("latency", 64'(lat), 64'(exp_lat(x, y)));
    chk_eq("result", 64'(result), 64'(want));
    chk_eq("ready_low_while_busy", 64'(bad_ready), 64'd0);
    chk_eq("busy_high", 64'(bad_busy), 64'd0);
    chk_eq("ready_excl_valid", 64'(in_ready), 64'd0);
    if (stall > 0) begin
      bad_hold = 0;
      repeat (stall) begin
        step();
        if (!out_valid || in_ready || result !== want) bad_hold = 1;
      end
      chk_eq("stall_hold", 64'(bad_hold), 64'd0);
      out_ready = 1'b1;
    end
    step();
    chk_eq("valid_clear", 64'(out_valid), 64'd0);
    chk_eq("ready_after", 64'(in_ready), 64'd1);
    chk_eq("result_kept", 64'(result), 64'(want));
  endtask

  initial begin
    bit saw_valid;
    logic [WIDTH-1:0] x, y;
    int stall;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) step();
    rst = 1'b0;
    chk_eq("rst_in_ready", 64'(in_ready), 64'd1);
    chk_eq("rst_out_valid", 64'(out_valid), 64'd0);
    chk_eq("rst_busy", 64'(busy), 64'd0);
    chk_eq("rst_result", 64'(result), 64'd0);

    run_op(16'h1234, 16'h5678, 0);
    chk_eq("known_1234x5678", 64'(result), 64'h0626_0060);
    run_op(16'hFFFF, 16'hFFFF, 0);
    chk_eq("known_ffffxffff", 64'(result), 64'hFFFE_0001);
    run_op(16'h0000, 16'hABCD, 0);
    run_op(16'hABCD, 16'h0000, 3);
    run_op(16'h00FF, 16'hFF00, 10);

    // Reset at edge 12 of an operation must discard it.
    out_ready = 1'b1;
    a         = 16'hBEEF;
    b         = 16'hCAFE;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    repeat (11) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    chk_eq("midrst_busy", 64'(busy), 64'd0);
    chk_eq("midrst_result", 64'(result), 64'd0);
    saw_valid = 0;
    repeat (LAT + 5) begin
      if (out_valid) saw_valid = 1;
      step();
    end
    chk_eq("midrst_no_valid", 64'(saw_valid), 64'd0);
    run_op(16'h0003, 16'h0005, 0);
    chk_eq("known_3x5", 64'(result), 64'h0000_000F);

    for (int i = 0; i < WIDTH; i++) begin
      x = WIDTH'(1) << i;
      run_op(x, WIDTH'($urandom), 0);
      run_op(16'hFFFF, x, $urandom_range(0, 2));
    end

    for (int n = 0; n < 250; n++) begin
      x = WIDTH'($urandom);
      y = WIDTH'($urandom);
      if ($urandom_range(0, 15) == 0) x = '0;
      if ($urandom_range(0, 15) == 0) y = '0;
      stall = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6));
      run_op(x, y, stall);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
